// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a per-register busy scoreboard.
// After reset a CLEAR sweep zeroes every register before Ready rises and traffic is accepted.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_RD-1:0]        RdEn,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     Alloc,
    input  logic [ADDR_W-1:0]        AllocAddr,
    output logic                     Ready
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     ready_q, ready_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    logic                     run_s;
    logic                     wr_fire_s;
    logic                     alloc_fire_s;
    logic                     mem_we_s;
    logic [ADDR_W-1:0]        mem_waddr_s;
    logic [DATA_W-1:0]        mem_wdata_s;

    // Writes and allocs only take effect in RUN; register 0 is never written or marked busy.
    assign run_s        = (state_q == ST_RUN);
    assign wr_fire_s    = run_s & WrEn & (WrAddr != ZERO_ADDR);
    assign alloc_fire_s = run_s & Alloc & (AllocAddr != ZERO_ADDR);

    // Next-state logic of the clear sweep and the Ready flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ONE_ADDR;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_CLEAR;
                    ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = ZERO_ADDR;
                ready_d = 1'b0;
            end
        endcase
    end

    // Busy table update: a same-cycle alloc overrides the write-back clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_fire_s && (AllocAddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_fire_s && (WrAddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Single array write port shared by the clear sweep and the write-back.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ZERO_ADDR;
        mem_wdata_s = ZERO_DATA;
        if (Rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_q;
        end else if (wr_fire_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = WrAddr;
            mem_wdata_s = WrData;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read ports: write-first bypass, hard-wired zero register, busy seen after this edge.
    always_comb begin
        logic [ADDR_W-1:0] addr_v;
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        addr_v    = ZERO_ADDR;
        for (int p = 0; p < NUM_RD; p++) begin
            addr_v = RdAddr[p*ADDR_W +: ADDR_W];
            if (!run_s) begin
                rd_data_d[p*DATA_W +: DATA_W] = ZERO_DATA;
                rd_busy_d[p]                  = 1'b0;
            end else if (!RdEn[p]) begin
                rd_data_d[p*DATA_W +: DATA_W] = rd_data_q[p*DATA_W +: DATA_W];
                rd_busy_d[p]                  = rd_busy_q[p];
            end else if (addr_v == ZERO_ADDR) begin
                rd_data_d[p*DATA_W +: DATA_W] = ZERO_DATA;
                rd_busy_d[p]                  = 1'b0;
            end else if (wr_fire_s && (WrAddr == addr_v)) begin
                rd_data_d[p*DATA_W +: DATA_W] = WrData;
                rd_busy_d[p]                  = busy_d[addr_v];
            end else begin
                rd_data_d[p*DATA_W +: DATA_W] = mem_q[addr_v];
                rd_busy_d[p]                  = busy_d[addr_v];
            end
        end
    end

    // Control, scoreboard and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= ZERO_ADDR;
            ready_q   <= 1'b0;
            busy_q    <= {DEPTH{1'b0}};
            rd_data_q <= {(NUM_RD*DATA_W){1'b0}};
            rd_busy_q <= {NUM_RD{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    // Register array storage; contents are defined by the clear sweep, not by reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign RdData = rd_data_q;
    assign RdBusy = rd_busy_q;
    assign Ready  = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: table-driven vectors through a scoreboard queue, hand-written
// reset/clear sequences, and a randomised burst against a reference model.
module tb_regfile_mp;

    logic        Clk;
    logic        Rst;
    logic [1:0]  RdEn;
    logic [9:0]  RdAddr;
    logic [63:0] RdData;
    logic [1:0]  RdBusy;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        Alloc;
    logic [4:0]  AllocAddr;
    logic        Ready;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .Clk(Clk), .Rst(Rst), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
        .RdBusy(RdBusy), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Alloc(Alloc), .AllocAddr(AllocAddr), .Ready(Ready)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        alloc;
        logic [4:0]  alloc_addr;
        logic [1:0]  rd_en;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[16];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] ref_mem  [32];
    logic        ref_busy [32];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        WrEn = 1'b0; WrAddr = 5'd0; WrData = 32'd0;
        Alloc = 1'b0; AllocAddr = 5'd0;
        RdEn = 2'b00; RdAddr = 10'd0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_d0"}, RdData[31:0], e.d0);
            check({tag, "_d1"}, RdData[63:32], e.d1);
            check({tag, "_b0"}, {31'd0, RdBusy[0]}, {31'd0, e.b0});
            check({tag, "_b1"}, {31'd0, RdBusy[1]}, {31'd0, e.b1});
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        WrEn = v.wr_en; WrAddr = v.wr_addr; WrData = v.wr_data;
        Alloc = v.alloc; AllocAddr = v.alloc_addr;
        RdEn = v.rd_en; RdAddr = {v.ra1, v.ra0};
        e.d0 = v.d0; e.d1 = v.d1; e.b0 = v.b0; e.b1 = v.b1;
        sb_q.push_back(e);
        step();
        pop_compare(tag);
    endtask

    // Counts edges until Ready rises, with garbage traffic that must be ignored.
    task automatic wait_ready(input string tag, input int exp_edges);
        int n;
        int bad;
        n = 0;
        bad = 0;
        WrEn = 1'b1; WrAddr = 5'd3; WrData = 32'hAAAA5555;
        Alloc = 1'b1; AllocAddr = 5'd4;
        RdEn = 2'b11; RdAddr = {5'd4, 5'd3};
        while (Ready !== 1'b1 && n < 100) begin
            if (RdData !== 64'd0 || RdBusy !== 2'b00) bad++;
            step();
            n++;
        end
        idle_inputs();
        check({tag, "_edges"}, n, exp_edges);
        check({tag, "_outs_zero"}, bad, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, Ready}, 32'd0);
        check({tag, "_rddata0"}, RdData[31:0], 32'd0);
        check({tag, "_rddata1"}, RdData[63:32], 32'd0);
        check({tag, "_rdbusy"}, {30'd0, RdBusy}, 32'd0);
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        Rst = 1'b0;
        #1;

        // Clear sequence: two reset cycles, then DEPTH cycles of sweep.
        Rst = 1'b1;
        step();
        check_reset_outputs("rst1");
        step();
        check_reset_outputs("rst2");
        Rst = 1'b0;
        wait_ready("clear", 32);

        for (int i = 0; i < 32; i++) begin
            v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'(i), 5'(31 - i),
                  32'd0, 32'd0, 1'b0, 1'b0};
            apply(v, $sformatf("zero_r%0d", i));
        end

        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0, 2'b11, 5'd7, 5'd5, 32'h00001234, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 2'b11, 5'd0, 5'd7, 32'd0,        32'h00001234, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b11, 5'd0, 5'd0, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b11, 5'd9, 5'd9, 32'd0,        32'd0,        1'b1, 1'b1};
        tbl[7]  = '{1'b1, 5'd9, 32'h00000055, 1'b0, 5'd0, 2'b01, 5'd9, 5'd0, 32'h00000055, 32'd0,        1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b10, 5'd0, 5'd9, 32'h00000055, 32'h00000055, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 5'd9, 32'h00000066, 1'b1, 5'd9, 2'b11, 5'd9, 5'd9, 32'h00000066, 32'h00000066, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b11, 5'd9, 5'd10, 32'h00000066, 32'd0,       1'b1, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 2'b11, 5'd0, 5'd9, 32'd0,        32'h00000066, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b11, 5'd7, 5'd5, 32'h00001234, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0, 2'b01, 5'd5, 5'd5, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h00001234, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 2'b10, 5'd0, 5'd5, 32'h00001234, 32'hCAFEF00D, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end
        idle_inputs();

        // Reset from RUN with live outputs, then a second reset at clear index 10.
        Rst = 1'b1;
        step();
        check_reset_outputs("rst3");
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check({"midclear", "_ready"}, {31'd0, Ready}, 32'd0);
        Rst = 1'b1;
        step();
        check_reset_outputs("rst4");
        Rst = 1'b0;
        wait_ready("reclear", 32);

        v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'd9, 5'd5, 32'd0, 32'd0, 1'b0, 1'b0};
        apply(v, "post_clear");

        // Randomised back-to-back traffic against a reference model.
        for (int a = 0; a < 32; a++) begin
            ref_mem[a]  = 32'd0;
            ref_busy[a] = 1'b0;
        end
        v.d0 = 32'd0; v.d1 = 32'd0; v.b0 = 1'b0; v.b1 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            logic [4:0]  ra;
            logic [31:0] dx;
            logic        bx;
            v.wr_en      = 1'($urandom_range(0, 1));
            v.wr_addr    = 5'($urandom_range(0, 7));
            v.wr_data    = $urandom;
            v.alloc      = ($urandom_range(0, 2) == 0);
            v.alloc_addr = 5'($urandom_range(0, 7));
            v.rd_en      = 2'($urandom_range(0, 3));
            v.ra0        = 5'($urandom_range(0, 7));
            v.ra1        = 5'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                ra = (p == 0) ? v.ra0 : v.ra1;
                if (v.rd_en[p]) begin
                    if (ra == 5'd0) begin
                        dx = 32'd0;
                        bx = 1'b0;
                    end else begin
                        dx = (v.wr_en && v.wr_addr == ra) ? v.wr_data : ref_mem[ra];
                        if (v.alloc && v.alloc_addr == ra) bx = 1'b1;
                        else if (v.wr_en && v.wr_addr == ra) bx = 1'b0;
                        else bx = ref_busy[ra];
                    end
                    if (p == 0) begin v.d0 = dx; v.b0 = bx; end
                    else begin v.d1 = dx; v.b1 = bx; end
                end
            end
            if (v.wr_en && v.wr_addr != 5'd0) begin
                ref_mem[v.wr_addr]  = v.wr_data;
                ref_busy[v.wr_addr] = 1'b0;
            end
            if (v.alloc && v.alloc_addr != 5'd0) ref_busy[v.alloc_addr] = 1'b1;
            apply(v, $sformatf("rnd%0d", k));
        end
        idle_inputs();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
